// File: rtl/fei4_cmd_pkg.sv
// fei4_cmd_pkg -- shared definitions for the FE-I4 command encoder.
// Holds the command-type and FSM state enums, frame header and field codes,
// frame lengths, and the frame builder used by the encoder's arbiter.
// Frames are built left-aligned to FRAME_W so the serializer always
// shifts out of bit FRAME_W-1.
package fei4_cmd_pkg;

   localparam int FRAME_W = 39;

   typedef enum logic [3:0] {
      TRIG    = 4'd0,
      BCR     = 4'd1,
      ECR     = 4'd2,
      CAL     = 4'd3,
      RDREG   = 4'd4,
      WRREG   = 4'd5,
      GRST    = 4'd6,
      GPULSE  = 4'd7,
      RUNMODE = 4'd8
   } cmd_type_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_e;

   // Headers
   localparam logic [4:0] HDR_TRIG = 5'b11101;
   localparam logic [4:0] HDR_CMD  = 5'b10110;
   localparam logic [3:0] HDR_SLOW = 4'b1000;

   // Fast-command fields
   localparam logic [3:0] FLD_BCR = 4'b0001;
   localparam logic [3:0] FLD_ECR = 4'b0010;
   localparam logic [3:0] FLD_CAL = 4'b0100;

   // Slow-command fields
   localparam logic [3:0] FLD_GRST    = 4'b1000;
   localparam logic [3:0] FLD_GPULSE  = 4'b1001;
   localparam logic [3:0] FLD_RUNMODE = 4'b1010;
   localparam logic [3:0] FLD_RDREG   = 4'b0001;
   localparam logic [3:0] FLD_WRREG   = 4'b0010;

   localparam logic [5:0] RUN_PATTERN  = 6'b111000;
   localparam logic [5:0] CONF_PATTERN = 6'b000111;

   // Frame lengths in bits
   localparam logic [5:0] LEN_TRIG  = 6'd5;
   localparam logic [5:0] LEN_FAST  = 6'd9;
   localparam logic [5:0] LEN_HDR   = 6'd17;
   localparam logic [5:0] LEN_SLOW  = 6'd23;
   localparam logic [5:0] LEN_WRREG = 6'd39;

   typedef struct packed {
      logic               valid;
      logic [5:0]         len;
      logic [FRAME_W-1:0] bits;
   } frame_t;

   // Build the left-aligned frame for a command; valid=0 for unsupported types.
   function automatic frame_t build_frame(input logic [3:0]  ty,
                                          input logic [3:0]  chipid,
                                          input logic [5:0]  addr,
                                          input logic [15:0] data);
      frame_t     f;
      logic [4:0] hdr;
      f     = '0;
      hdr   = HDR_CMD;
      case (ty)
         TRIG:    begin f.valid = 1'b1; f.len = LEN_TRIG;  f.bits = {HDR_TRIG, 34'd0}; end
         BCR:     begin f.valid = 1'b1; f.len = LEN_FAST;  f.bits = {hdr, FLD_BCR, 30'd0}; end
         ECR:     begin f.valid = 1'b1; f.len = LEN_FAST;  f.bits = {hdr, FLD_ECR, 30'd0}; end
         CAL:     begin f.valid = 1'b1; f.len = LEN_FAST;  f.bits = {hdr, FLD_CAL, 30'd0}; end
         GRST:    begin f.valid = 1'b1; f.len = LEN_HDR;
                        f.bits = {hdr, HDR_SLOW, FLD_GRST, chipid, 22'd0}; end
         GPULSE:  begin f.valid = 1'b1; f.len = LEN_SLOW;
                        f.bits = {hdr, HDR_SLOW, FLD_GPULSE, chipid, addr, 16'd0}; end
         RUNMODE: begin f.valid = 1'b1; f.len = LEN_SLOW;
                        f.bits = {hdr, HDR_SLOW, FLD_RUNMODE, chipid,
                                  (addr[0] ? RUN_PATTERN : CONF_PATTERN), 16'd0}; end
         RDREG:   begin f.valid = 1'b1; f.len = LEN_SLOW;
                        f.bits = {hdr, HDR_SLOW, FLD_RDREG, chipid, addr, 16'd0}; end
         WRREG:   begin f.valid = 1'b1; f.len = LEN_WRREG;
                        f.bits = {hdr, HDR_SLOW, FLD_WRREG, chipid, addr, data}; end
         default: f = '0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/fei4_cmd_serializer.sv
// fei4_cmd_serializer -- left-aligned shift register plus remaining-bit counter.
// Ports:
//   clk, RstB          clock, synchronous active-low reset
//   load, load_bits,   load a frame (MSB at bit FRAME_W-1) and its length
//   load_len
//   shift              advance one bit
//   msb                current serial bit
//   last_bit           the bit currently presented is the last of the frame
module fei4_cmd_serializer
   import fei4_cmd_pkg::*;
(
   input  logic               clk,
   input  logic               RstB,
   input  logic               load,
   input  logic [FRAME_W-1:0] load_bits,
   input  logic [5:0]         load_len,
   input  logic               shift,
   output logic               msb,
   output logic               last_bit
);

   logic [FRAME_W-1:0] sreg_r;
   logic [5:0]         cnt_r;

   // Shift register and bit counter; load wins over shift.
   always_ff @(posedge clk) begin
      if (!RstB) begin
         sreg_r <= '0;
         cnt_r  <= 6'd0;
      end else if (load) begin
         sreg_r <= load_bits;
         cnt_r  <= load_len;
      end else if (shift && (cnt_r != 6'd0)) begin
         sreg_r <= {sreg_r[FRAME_W-2:0], 1'b0};
         cnt_r  <= cnt_r - 6'd1;
      end
   end

   assign msb      = sreg_r[FRAME_W-1];
   assign last_bit = (cnt_r == 6'd1);

endmodule

// File: rtl/fei4_cmd_encoder.sv
// fei4_cmd_encoder -- FE-I4 tester-side command generator (one DCI bit per BC clock).
// Arbitrates queued LV1 triggers against a valid/ready command port; triggers
// win at frame boundaries and frames are separated by GAP_CYCLES zeros.
// Ports:
//   clk, RstB                     BC clock, synchronous active-low reset
//   trig_req                      one-cycle trigger request
//   cmd_valid/cmd_ready           command handshake
//   cmd_type/chipid/addr/data     command fields
//   dci                           serial command stream
//   busy                          frame or gap in progress
//   trig_pending, trig_overflow   trigger queue depth, sticky drop flag
//   err_invalid                   pulse after accepting an unsupported cmd_type
// Build option: CMD_TRIG_QUEUE_EN selects the counting trigger queue
// (saturating at TRIG_QUEUE_DEPTH); otherwise a single pending flag is used.
module fei4_cmd_encoder
   import fei4_cmd_pkg::*;
#(
   parameter int GAP_CYCLES       = 1,
   parameter int TRIG_QUEUE_DEPTH = 15
) (
   input  logic        clk,
   input  logic        RstB,
   input  logic        trig_req,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_type,
   input  logic [3:0]  cmd_chipid,
   input  logic [5:0]  cmd_addr,
   input  logic [15:0] cmd_data,
   output logic        dci,
   output logic        busy,
   output logic [3:0]  trig_pending,
   output logic        trig_overflow,
   output logic        err_invalid
);

`ifdef CMD_TRIG_QUEUE_EN
   localparam logic [3:0] Q_MAX = 4'(TRIG_QUEUE_DEPTH);
`else
   // Single-entry flag: the configured depth is capped at one.
   localparam logic [3:0] Q_MAX = (TRIG_QUEUE_DEPTH > 1) ? 4'd1 : 4'(TRIG_QUEUE_DEPTH);
`endif

   state_e             state_r, state_next_s;
   logic [3:0]         gap_cnt_r;
   logic [3:0]         pend_r;
   logic               ovf_r;
   logic               err_r;

   logic               launch_slot_s;
   logic               trig_launch_s;
   logic               cmd_ready_s;
   logic               cmd_acc_s;
   frame_t             cmd_frame_s;
   frame_t             trig_frame_s;
   logic               load_s;
   logic [FRAME_W-1:0] load_bits_s;
   logic [5:0]         load_len_s;
   logic               ser_msb_s;
   logic               ser_last_s;

   // A launch may be decided in IDLE or in the final GAP cycle; never during reset.
   assign launch_slot_s = RstB && ((state_r == IDLE) ||
                                   ((state_r == GAP) && (gap_cnt_r == 4'd0)));
   assign trig_launch_s = launch_slot_s && ((pend_r != 4'd0) || trig_req);
   assign cmd_ready_s   = launch_slot_s && (pend_r == 4'd0) && !trig_req;
   assign cmd_acc_s     = cmd_valid && cmd_ready_s;
   assign cmd_frame_s   = build_frame(cmd_type, cmd_chipid, cmd_addr, cmd_data);
   assign trig_frame_s  = build_frame(4'(TRIG), 4'd0, 6'd0, 16'd0);

   // Next-state and frame-load selection.
   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      load_bits_s  = '0;
      load_len_s   = 6'd0;
      case (state_r)
         IDLE, GAP: begin
            if (trig_launch_s) begin
               load_s       = 1'b1;
               load_bits_s  = trig_frame_s.bits;
               load_len_s   = trig_frame_s.len;
               state_next_s = SHIFT;
            end else if (cmd_acc_s && cmd_frame_s.valid) begin
               load_s       = 1'b1;
               load_bits_s  = cmd_frame_s.bits;
               load_len_s   = cmd_frame_s.len;
               state_next_s = SHIFT;
            end else if (launch_slot_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = state_r;
            end
         end
         SHIFT: begin
            if (ser_last_s) begin
               state_next_s = GAP;
            end else begin
               state_next_s = SHIFT;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State register and gap countdown (reaches zero in the final GAP cycle).
   always_ff @(posedge clk) begin
      if (!RstB) begin
         state_r   <= IDLE;
         gap_cnt_r <= 4'd0;
      end else begin
         state_r <= state_next_s;
         if ((state_r == SHIFT) && ser_last_s) begin
            gap_cnt_r <= 4'(GAP_CYCLES - 1);
         end else if ((state_r == GAP) && (gap_cnt_r != 4'd0)) begin
            gap_cnt_r <= gap_cnt_r - 4'd1;
         end
      end
   end

   // Trigger queue: a request and a launch in the same cycle cancel out.
   always_ff @(posedge clk) begin
      if (!RstB) begin
         pend_r <= 4'd0;
         ovf_r  <= 1'b0;
      end else if (trig_req && !trig_launch_s) begin
         if (pend_r == Q_MAX) begin
            ovf_r <= 1'b1;
         end else begin
            pend_r <= pend_r + 4'd1;
         end
      end else if (!trig_req && trig_launch_s) begin
         pend_r <= pend_r - 4'd1;
      end
   end

   // Invalid-command pulse, one cycle after acceptance.
   always_ff @(posedge clk) begin
      if (!RstB) begin
         err_r <= 1'b0;
      end else begin
         err_r <= cmd_acc_s && !cmd_frame_s.valid;
      end
   end

   fei4_cmd_serializer u_ser (
      .clk       (clk),
      .RstB      (RstB),
      .load      (load_s),
      .load_bits (load_bits_s),
      .load_len  (load_len_s),
      .shift     (state_r == SHIFT),
      .msb       (ser_msb_s),
      .last_bit  (ser_last_s)
   );

   assign dci           = (state_r == SHIFT) ? ser_msb_s : 1'b0;
   assign busy          = (state_r != IDLE);
   assign cmd_ready     = cmd_ready_s;
   assign trig_pending  = pend_r;
   assign trig_overflow = ovf_r;
   assign err_invalid   = err_r;

endmodule

// File: tb/tb_fei4_cmd_encoder.sv
// tb_fei4_cmd_encoder -- directed, table-driven bench for fei4_cmd_encoder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fei4_cmd_encoder;

`ifdef CMD_TRIG_QUEUE_EN
   localparam int Q_MAX = 15;
`else
   localparam int Q_MAX = 1;
`endif

   logic        clk = 1'b0;
   logic        RstB;
   logic        trig_req;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_type;
   logic [3:0]  cmd_chipid;
   logic [5:0]  cmd_addr;
   logic [15:0] cmd_data;
   logic        dci;
   logic        busy;
   logic [3:0]  trig_pending;
   logic        trig_overflow;
   logic        err_invalid;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [38:0] WR_FRAME = 39'b10110_1000_0010_0000_000010_0001_0010_0011_0100;

   fei4_cmd_encoder #(.GAP_CYCLES(1), .TRIG_QUEUE_DEPTH(15)) dut (
      .clk(clk), .RstB(RstB), .trig_req(trig_req),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_chipid(cmd_chipid), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .dci(dci), .busy(busy), .trig_pending(trig_pending),
      .trig_overflow(trig_overflow), .err_invalid(err_invalid)
   );

   always #12 clk = ~clk;

   typedef struct {
      logic [3:0]  ty;
      logic [3:0]  chip;
      logic [5:0]  addr;
      logic [15:0] data;
      int          len;
      logic [38:0] exp;
      logic        err;
   } vec_t;

   vec_t vec[11];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic collect(input int n, output logic [127:0] v);
      v = '0;
      for (int i = 0; i < n; i++) begin
         v = {v[126:0], dci};
         @(negedge clk);
      end
   endtask

   // Present a command while idle; returns at the falling edge showing its first bit.
   task automatic send(input logic [3:0] ty, input logic [3:0] chip,
                       input logic [5:0] addr, input logic [15:0] data);
      cmd_type = ty; cmd_chipid = chip; cmd_addr = addr; cmd_data = data;
      cmd_valid = 1'b1;
      #1;
      check("cmd_ready_idle", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [127:0] got;
      logic [127:0] exp;
      logic         seen;

      vec[0]  = '{4'd1, 4'd0, 6'd0,  16'd0, 9,  39'b101100001, 1'b0};
      vec[1]  = '{4'd2, 4'd0, 6'd0,  16'd0, 9,  39'b101100010, 1'b0};
      vec[2]  = '{4'd3, 4'd0, 6'd0,  16'd0, 9,  39'b101100100, 1'b0};
      vec[3]  = '{4'd0, 4'd0, 6'd0,  16'd0, 5,  39'b11101, 1'b0};
      vec[4]  = '{4'd6, 4'd5, 6'd0,  16'd0, 17, 39'b10110_1000_1000_0101, 1'b0};
      vec[5]  = '{4'd7, 4'd3, 6'd10, 16'd0, 23, 39'b10110_1000_1001_0011_001010, 1'b0};
      vec[6]  = '{4'd8, 4'd0, 6'h01, 16'd0, 23, 39'b10110_1000_1010_0000_111000, 1'b0};
      vec[7]  = '{4'd8, 4'd15, 6'h3E, 16'd0, 23, 39'b10110_1000_1010_1111_000111, 1'b0};
      vec[8]  = '{4'd4, 4'd1, 6'h3F, 16'd0, 23, 39'b10110_1000_0001_0001_111111, 1'b0};
      vec[9]  = '{4'd5, 4'd0, 6'd2,  16'h1234, 39, WR_FRAME, 1'b0};
      vec[10] = '{4'd12, 4'd7, 6'h2A, 16'hFFFF, 0, 39'd0, 1'b1};

      RstB = 1'b0; trig_req = 1'b0; cmd_valid = 1'b0;
      cmd_type = 4'd0; cmd_chipid = 4'd0; cmd_addr = 6'd0; cmd_data = 16'd0;
      repeat (3) @(negedge clk);
      check("rst_dci", dci, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_pending", trig_pending, 0);
      check("rst_overflow", trig_overflow, 0);
      check("rst_err", err_invalid, 0);
      RstB = 1'b1;
      @(negedge clk);

      // Table of single commands from IDLE
      for (int i = 0; i < 11; i++) begin
         send(vec[i].ty, vec[i].chip, vec[i].addr, vec[i].data);
         if (vec[i].err) begin
            check("invalid_err_pulse", err_invalid, 1);
            check("invalid_dci", dci, 0);
            check("invalid_busy", busy, 0);
            @(negedge clk);
            check("invalid_err_clear", err_invalid, 0);
         end else begin
            check("valid_no_err", err_invalid, 0);
            collect(vec[i].len, got);
            check("frame_bits", got, {89'd0, vec[i].exp});
            check("gap_dci", dci, 0);
            check("gap_busy", busy, 1);
            @(negedge clk);
            check("idle_busy", busy, 0);
         end
      end

      // Trigger requested in IDLE
      trig_req = 1'b1;
      #1;
      check("trig_blocks_ready", cmd_ready, 0);
      @(negedge clk);
      trig_req = 1'b0;
      collect(5, got);
      check("trig_frame", got, 128'b11101);
      check("trig_gap_busy", busy, 1);
      @(negedge clk);
      check("trig_idle_busy", busy, 0);
      check("trig_idle_pending", trig_pending, 0);

      // Trigger requested mid WrReg: follows after exactly one zero
      send(4'd5, 4'd0, 6'd2, 16'h1234);
      got = '0; seen = 1'b0;
      for (int i = 0; i < 45; i++) begin
         got = {got[126:0], dci};
         if (cmd_ready) seen = 1'b1;
         trig_req = (i == 5);
         @(negedge clk);
      end
      check("wr_then_trig", got, {83'd0, WR_FRAME, 1'b0, 5'b11101});
      check("ready_low_until_trig", seen, 0);
      @(negedge clk);
      check("wr_trig_idle", busy, 0);
      check("wr_trig_ready", cmd_ready, 1);

      // 20 requests during a frame: queue saturates
      send(4'd5, 4'd0, 6'd2, 16'h1234);
      got = '0;
      for (int i = 0; i < 39; i++) begin
         got = {got[126:0], dci};
         trig_req = (i < 20);
         @(negedge clk);
      end
      trig_req = 1'b0;
      check("sat_frame", got, {89'd0, WR_FRAME});
      check("sat_pending", trig_pending, Q_MAX);
      check("sat_overflow", trig_overflow, 1);
      exp = '0;
      for (int k = 0; k < Q_MAX; k++) exp = {exp[121:0], 6'b011101};
      collect(6 * Q_MAX, got);
      check("sat_trig_train", got, exp);
      check("sat_last_gap_busy", busy, 1);
      check("sat_drained", trig_pending, 0);
      @(negedge clk);
      check("sat_idle", busy, 0);
      check("sat_overflow_sticky", trig_overflow, 1);

      // ECR and trigger together in IDLE: trigger first
      cmd_type = 4'd2; cmd_chipid = 4'd0; cmd_addr = 6'd0; cmd_data = 16'd0;
      cmd_valid = 1'b1; trig_req = 1'b1;
      #1;
      check("ecr_trig_ready", cmd_ready, 0);
      @(negedge clk);
      trig_req = 1'b0;
      got = '0; seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         got = {got[126:0], dci};
         if (cmd_valid && cmd_ready) seen = 1'b1;
         @(negedge clk);
         if (seen) cmd_valid = 1'b0;
      end
      cmd_valid = 1'b0;
      check("trig_then_ecr", got, 128'b11101_0_101100010_0);
      check("ecr_accepted", seen, 1);
      check("ecr_idle", busy, 0);

      // Reset during bit 10 of a RdReg with a trigger queued
      send(4'd4, 4'd1, 6'd5, 16'd0);
      got = '0;
      for (int i = 0; i < 11; i++) begin
         got = {got[126:0], dci};
         trig_req = (i == 2);
         if (i == 10) RstB = 1'b0;
         @(negedge clk);
      end
      trig_req = 1'b0;
      check("rdreg_prefix", got, 128'b10110100000);
      check("midrst_dci", dci, 0);
      check("midrst_pending", trig_pending, 0);
      check("midrst_busy", busy, 0);
      check("midrst_overflow", trig_overflow, 0);
      RstB = 1'b1;
      @(negedge clk);
      check("post_rst_dci", dci, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fei4_cmd_encoder.md
Name: fei4_cmd_encoder

Overview:
- Tester-side command generator. Serializes FE-I4 trigger, fast and slow commands, MSB first, onto the DCI line consumed by the chip's command decoder.
- Runs on the 40 MHz bunch-crossing clock, one DCI bit per cycle.
- Arbitrates between a trigger-request pulse and a valid/ready command port. Triggers take priority at frame boundaries and are never inserted inside a frame.

Parameters:
- GAP_CYCLES, 1, number of forced-zero DCI bits between consecutive frames (legal range 1..15).
- TRIG_QUEUE_DEPTH, 15, saturation value of the pending-trigger counter (legal range 1..15).

Ports:
- clk  in  1  40 MHz bunch-crossing clock.
- RstB  in  1  synchronous, active-low reset.
- trig_req  in  1  one-cycle request for an LV1 trigger.
- cmd_valid  in  1  command present on cmd_* inputs.
- cmd_ready  out  1  encoder accepts the command this cycle.
- cmd_type  in  4  command encoding; values defined in the package.
- cmd_chipid  in  4  ChipID field of slow commands.
- cmd_addr  in  6  register address for RdReg/WrReg; pulse width for GlobalPulse; bit0 selects run (1) or conf (0) for RunMode.
- cmd_data  in  16  WrReg payload.
- dci  out  1  serial command stream.
- busy  out  1  high while a frame or gap is in progress.
- trig_pending  out  4  number of queued triggers.
- trig_overflow  out  1  sticky; set when a trigger is lost to saturation.
- err_invalid  out  1  one-cycle pulse when an unsupported cmd_type is accepted.

Behaviour:
Reset values
- While RstB=0 at a clk edge: dci=0, busy=0, cmd_ready=0, trig_pending=0, trig_overflow=0, err_invalid=0, state=IDLE.
- A reset mid-frame truncates the frame: dci=0 from the next cycle and the queue is cleared.

Frame formats (MSB first)
- Trigger: 11101 (5 bits).
- Fast: 10110 + 4-bit field (9 bits). BCR=0001, ECR=0010, CAL=0100.
- Slow header: 10110 1000 + 4-bit field + chipid (17 bits).
- Slow fields:
  - GlobalReset 1000: header only, 17 bits.
  - GlobalPulse 1001: + 6-bit width, 23 bits.
  - RunMode 1010: + 111000 (run) or 000111 (conf), 23 bits.
  - RdReg 0001: + addr, 23 bits.
  - WrReg 0010: + addr + data, 39 bits.

States: IDLE, SHIFT, GAP
- IDLE, dci=0:
  - If trig_pending>0 or trig_req: load the trigger frame and go to SHIFT.
  - Otherwise, if cmd_valid&&cmd_ready: load the command frame and go to SHIFT.
- SHIFT: dci = MSB of the shift register; shift each cycle. On the last bit, go to GAP.
- GAP: dci=0 for GAP_CYCLES cycles. A pending launch is decided in the final GAP cycle, so exactly GAP_CYCLES zeros separate back-to-back frames. With nothing pending, go to IDLE.

Handshake and latency
- cmd_ready = (IDLE, or final GAP cycle) && trig_pending==0 && !trig_req.
- cmd_* is captured in the acceptance cycle. The first DCI bit appears the following cycle.
- trig_req seen in IDLE: the first trigger bit appears the next cycle.

Trigger queue
- trig_req increments trig_pending. Launching a trigger decrements it.
- A request and a launch in the same cycle leave the count unchanged.
- A request at saturation (TRIG_QUEUE_DEPTH) is dropped and sets trig_overflow.
- trig_overflow clears only on reset.

Invalid commands
- An invalid cmd_type is still accepted: cmd_ready handshake completes, err_invalid pulses the next cycle, no frame is sent and the state stays IDLE.
- busy = (state != IDLE).

Optional Feature:
CMD_TRIG_QUEUE_EN
- Defined: counting trigger queue as described above.
- Undefined: single-entry pending flag. trig_pending reads 0 or 1. A second trig_req while the flag is set is dropped and sets trig_overflow. TRIG_QUEUE_DEPTH is ignored.

Decomposition:
- Package fei4_cmd_pkg holds:
  - cmd_type enum: TRIG=0, BCR=1, ECR=2, CAL=3, RDREG=4, WRREG=5, GRST=6, GPULSE=7, RUNMODE=8; 9..15 invalid.
  - Header constants 11101, 10110, 1000.
  - Per-type field codes and frame lengths (5/9/17/23/39).
  - Maximum frame width of 39.
  - State enum.
- Sub-module fei4_cmd_serializer: 39-bit shift register plus 6-bit bit counter with load/length inputs and a last_bit output. The top holds the arbiter, queue and FSM.

Test Plan:
- WrReg, chipid=0, addr=2, data=0x1234 -> starting the cycle after acceptance, dci = 101101000 0010 0000 000010 0001001000110100 (39 bits), then 1 zero, busy low after the gap.
- trig_req in IDLE -> dci 11101 starting the next cycle. A trig_req during a WrReg frame -> 11101 starts exactly 1 zero after that frame's last bit, and cmd_ready stays low until the trigger launches.
- 20 trig_req pulses during one 39-bit frame -> trig_pending saturates at 15, trig_overflow=1, exactly 15 trigger frames follow, each separated by 1 zero.
- ECR queued with a simultaneous trig_req in IDLE -> trigger sent first, then 101100010.
- cmd_type=12 accepted -> err_invalid pulses once, dci stays 0. RstB=0 during bit 10 of a RdReg frame -> dci=0 the next cycle and trig_pending=0.
- Undefined CMD_TRIG_QUEUE_EN: 3 trig_req during a frame -> 1 trigger sent, trig_overflow=1.
